ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Configuration-chain loader directly upstream of fpga_top.
- Accepts a bitstream as a valid/ready stream of NUM_CHAINS-bit words and shifts one bit per chain per accepted word into the ccff_head inputs, producing a single-cycle shift strobe per bit.
- Holds the user fabric in reset during loading, releases it after a settle delay, and then flags configuration done.
- Replaces the behavioural bitstream include with synthesizable load logic in bitstream benches.

Parameters:
- NUM_CHAINS, 10: number of parallel configuration chains (ccff_head width).
- CHAIN_LEN, 4096: shifts per chain for one full configuration.
- TIMEOUT, 1024: maximum idle cycles waiting for bs_valid during LOAD before error.
- RELEASE_DLY, 8: cycles between the last shift and fabric reset release.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load.
- bs_data  in  NUM_CHAINS  bitstream word; bit i goes to chain i.
- bs_valid  in  1  bs_data valid.
- bs_ready  out  1  loader accepts a word this cycle.
- ccff_head  out  NUM_CHAINS  registered serial data to chain heads, indexed [0:NUM_CHAINS-1].
- prog_clk_en  out  1  one-cycle shift strobe, aligned with ccff_head.
- fabric_resetn  out  1  active-low reset to the user fabric.
- cfg_done  out  1  configuration complete (level).
- cfg_error  out  1  load aborted on timeout (level).
- bits_loaded  out  $clog2(CHAIN_LEN+1)  number of shifts completed.

Behaviour:
- The clock is clk. Reset is synchronous and active-high on reset.
- Reset values:
  - FSM = IDLE.
  - ccff_head, prog_clk_en, bs_ready, cfg_done, cfg_error, bits_loaded, all counters = 0.
  - fabric_resetn = 0.
- FSM states: IDLE, LOAD, SETTLE, DONE, ERROR.
- IDLE:
  - bs_ready = 0.
  - start -> LOAD; clears bits_loaded and the timeout counter.
- LOAD:
  - bs_ready = 1 (combinational from state).
  - Accept when bs_valid & bs_ready. The next cycle has ccff_head = bs_data, prog_clk_en = 1 and bits_loaded + 1.
  - On cycles without an accept, prog_clk_en = 0 and ccff_head holds its value.
  - The first accepted word is the bit that ends at the tail end of each chain (standard shift order).
  - Timeout counter:
    - Clears on every accept and increments otherwise.
    - On reaching TIMEOUT with no accept -> ERROR.
  - The accept that makes bits_loaded == CHAIN_LEN -> SETTLE. bs_ready drops in the same cycle the last word's strobe appears, so no extra word is ever accepted.
  - An accept and a timeout in the same cycle resolve as the accept.
- SETTLE:
  - fabric_resetn stays 0.
  - Counts RELEASE_DLY cycles, then -> DONE.
- DONE:
  - cfg_done = 1 and fabric_resetn = 1, both registered and entering together.
  - start -> LOAD; cfg_done and fabric_resetn drop to 0 in the following cycle.
- ERROR:
  - cfg_error = 1 and fabric_resetn = 0.
  - start -> LOAD and clears cfg_error.
- start in LOAD or SETTLE is ignored.
- bs_valid outside LOAD is ignored.
- reset asserted mid-LOAD or mid-SETTLE returns to reset values next edge; no partial strobe is emitted.
- Latency: accept to strobe is 1 cycle. Last strobe to cfg_done is RELEASE_DLY+1 cycles.
- Minimum load time is CHAIN_LEN cycles (bs_valid held high).

Decomposition:
- Shared package ccff_loader_pkg:
  - FSM state enum.
  - Default constants NUM_CHAINS_DEF = 10 and CHAIN_LEN_DEF.
- One natural sub-module: ccff_loader_timeout. It is a reusable saturating idle counter with clear/enable inputs and an expired output, also used for the SETTLE delay.

Test Plan:
- NUM_CHAINS=2, CHAIN_LEN=4, RELEASE_DLY=2; start, bs_valid held high, words 01,10,11,00:
  - prog_clk_en high for exactly 4 consecutive cycles with ccff_head = 01,10,11,00.
  - cfg_done = 1 and fabric_resetn = 1 three cycles after the last strobe.
  - bits_loaded = 4.
- Same configuration, bs_valid toggling every other cycle:
  - Exactly 4 strobes, spaced by 2 cycles.
  - No word accepted after the 4th.
  - cfg_done as above.
- TIMEOUT=5, two words then bs_valid low:
  - ERROR after 5 idle cycles: cfg_error = 1, fabric_resetn = 0, bits_loaded = 2.
  - A subsequent start clears cfg_error and a full load completes.
- reset pulsed after 2 of 4 shifts:
  - Next cycle all outputs are at reset values.
  - Further bs_valid is not accepted until start.
- In DONE, start with a new 4-word stream:
  - cfg_done and fabric_resetn fall next cycle.
  - Reload completes with the new ccff_head sequence.
- start pulsed during LOAD:
  - Ignored; the count continues and exactly CHAIN_LEN strobes occur.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
// ccff_loader_pkg -- shared FSM state type and default sizing for the loader
// Revision 1.0
// ============================================================================
package ccff_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERROR  = 3'd4
   } ccff_state_e;

   localparam int NUM_CHAINS_DEF  = 10;
   localparam int CHAIN_LEN_DEF   = 4096;
   localparam int TIMEOUT_DEF     = 1024;
   localparam int RELEASE_DLY_DEF = 8;

   // Width of a counter that must be able to hold max_val itself
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_loader_timeout.sv
`default_nettype none
// ============================================================================
// ccff_loader_timeout -- saturating idle counter; o_expired marks the LIMIT-th enabled cycle
// Revision 1.0
// ============================================================================
module ccff_loader_timeout
   import ccff_loader_pkg::*;
#(
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int            CW     = cnt_width(LIMIT);
   localparam logic [CW-1:0] c_sat  = CW'(LIMIT);
   localparam logic [CW-1:0] c_last = (LIMIT < 1) ? '0 : CW'(LIMIT - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != c_sat)) begin
         r_count <= r_count + 1'b1;
      end
   end

   // Combinational so the owner can act on the same edge the limit is hit
   assign o_expired = i_en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// ccff_chain_loader -- streams a bitstream into parallel CCFF chains, then releases the fabric
// Revision 1.0
// ============================================================================
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int NUM_CHAINS  = NUM_CHAINS_DEF,
   parameter int CHAIN_LEN   = CHAIN_LEN_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int RELEASE_DLY = RELEASE_DLY_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [NUM_CHAINS-1:0]          bs_data,
   input  logic                           bs_valid,
   output logic                           bs_ready,
   output logic [0:NUM_CHAINS-1]          ccff_head,
   output logic                           prog_clk_en,
   output logic                           fabric_resetn,
   output logic                           cfg_done,
   output logic                           cfg_error,
   output logic [$clog2(CHAIN_LEN+1)-1:0] bits_loaded
);

   localparam int            BW         = $clog2(CHAIN_LEN + 1);
   localparam logic [BW-1:0] c_last_bit = BW'(CHAIN_LEN - 1);

   ccff_state_e           r_state;
   logic [NUM_CHAINS-1:0] r_head;
   logic                  r_strobe;
   logic                  r_done;
   logic                  r_error;
   logic                  r_resetn;
   logic [BW-1:0]         r_bits;

   logic w_load;
   logic w_settle;
   logic w_accept;
   logic w_last_word;
   logic w_idle_expired;
   logic w_settle_expired;

   assign w_load      = (r_state == ST_LOAD);
   assign w_settle    = (r_state == ST_SETTLE);
   assign w_accept    = w_load && bs_valid;
   assign w_last_word = w_accept && (r_bits == c_last_bit);

   ccff_loader_timeout #(
      .LIMIT (TIMEOUT)
   ) u_idle_timer (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (!w_load || w_accept),
      .i_en      (w_load && !w_accept),
      .o_expired (w_idle_expired)
   );

   // SETTLE spans RELEASE_DLY+1 cycles so cfg_done lands RELEASE_DLY+1 after the last strobe
   ccff_loader_timeout #(
      .LIMIT (RELEASE_DLY + 1)
   ) u_settle_timer (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (!w_settle),
      .i_en      (w_settle),
      .o_expired (w_settle_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_head   <= '0;
         r_strobe <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
         r_resetn <= 1'b0;
         r_bits   <= '0;
      end else begin
         r_strobe <= w_accept;
         if (w_accept) begin
            r_head <= bs_data;
            r_bits <= r_bits + 1'b1;
         end
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  r_state  <= ST_LOAD;
                  r_bits   <= '0;
                  r_done   <= 1'b0;
                  r_error  <= 1'b0;
                  r_resetn <= 1'b0;
               end
            end
            ST_LOAD: begin
               // An accept always beats a coincident timeout
               if (w_last_word) begin
                  r_state <= ST_SETTLE;
               end else if (w_idle_expired) begin
                  r_state <= ST_ERROR;
                  r_error <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (w_settle_expired) begin
                  r_state  <= ST_DONE;
                  r_done   <= 1'b1;
                  r_resetn <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_head_map
      assign ccff_head[gi] = r_head[gi];
   end

   assign bs_ready      = w_load;
   assign prog_clk_en   = r_strobe;
   assign fabric_resetn = r_resetn;
   assign cfg_done      = r_done;
   assign cfg_error     = r_error;
   assign bits_loaded   = r_bits;

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// tb_ccff_chain_loader -- directed scenarios plus random traffic against a cycle-timed reference
// Revision 1.0
// ============================================================================
module tb_ccff_chain_loader;

   localparam int NC = 2;
   localparam int CL = 4;
   localparam int TO = 5;
   localparam int RD = 2;
   localparam int BW = $clog2(CL + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [NC-1:0] bs_data;
   logic          bs_valid;
   logic          bs_ready;
   logic [0:NC-1] ccff_head;
   logic          prog_clk_en;
   logic          fabric_resetn;
   logic          cfg_done;
   logic          cfg_error;
   logic [BW-1:0] bits_loaded;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: phase flags, words shifted, idle run length and release time
   bit            m_load, m_settle, m_done, m_err, m_resetn, m_strobe;
   int            m_bits, m_idle, m_done_at;
   logic [NC-1:0] m_head;

   ccff_chain_loader #(
      .NUM_CHAINS  (NC),
      .CHAIN_LEN   (CL),
      .TIMEOUT     (TO),
      .RELEASE_DLY (RD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .bs_data       (bs_data),
      .bs_valid      (bs_valid),
      .bs_ready      (bs_ready),
      .ccff_head     (ccff_head),
      .prog_clk_en   (prog_clk_en),
      .fabric_resetn (fabric_resetn),
      .cfg_done      (cfg_done),
      .cfg_error     (cfg_error),
      .bits_loaded   (bits_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [NC-1:0] head_vec();
      logic [NC-1:0] v;
      for (int i = 0; i < NC; i++) v[i] = ccff_head[i];
      return v;
   endfunction

   task automatic model_edge(input bit s, input bit v, input logic [NC-1:0] d, input bit r);
      cyc++;
      if (r) begin
         {m_load, m_settle, m_done, m_err, m_resetn, m_strobe} = '0;
         m_bits = 0;
         m_idle = 0;
         m_head = '0;
         return;
      end
      m_strobe = 1'b0;
      if (m_load) begin
         if (v) begin
            m_strobe = 1'b1;
            m_head   = d;
            m_bits++;
            m_idle   = 0;
            if (m_bits == CL) begin
               m_load    = 1'b0;
               m_settle  = 1'b1;
               m_done_at = cyc + RD + 1;
            end
         end else begin
            m_idle++;
            if (m_idle == TO) begin
               m_load = 1'b0;
               m_err  = 1'b1;
            end
         end
      end else if (m_settle) begin
         if (cyc == m_done_at) begin
            m_settle = 1'b0;
            m_done   = 1'b1;
            m_resetn = 1'b1;
         end
      end else if (s) begin
         m_load   = 1'b1;
         m_bits   = 0;
         m_idle   = 0;
         m_done   = 1'b0;
         m_err    = 1'b0;
         m_resetn = 1'b0;
      end
   endtask

   // One clock: drive at negedge, advance model at posedge, compare at next negedge
   task automatic step(input bit s, input bit v, input logic [NC-1:0] d, input bit r);
      reset    = r;
      start    = s;
      bs_valid = v;
      bs_data  = d;
      #1;
      chk("bs_ready", 32'(bs_ready), 32'(m_load));
      @(posedge clk);
      model_edge(s, v, d, r);
      @(negedge clk);
      chk("prog_clk_en", 32'(prog_clk_en), 32'(m_strobe));
      chk("ccff_head", 32'(head_vec()), 32'(m_head));
      chk("bits_loaded", 32'(bits_loaded), 32'(m_bits));
      chk("cfg_done", 32'(cfg_done), 32'(m_done));
      chk("cfg_error", 32'(cfg_error), 32'(m_err));
      chk("fabric_resetn", 32'(fabric_resetn), 32'(m_resetn));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, NC'($urandom), 1'b0);
   endtask

   task automatic load_seq(input logic [NC-1:0] w0, w1, w2, w3, input bit gaps);
      logic [NC-1:0] words [4];
      words = '{w0, w1, w2, w3};
      step(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, words[i], 1'b0);
         if (gaps) step(1'b0, 1'b0, ~words[i], 1'b0);
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      bs_valid = 1'b0;
      bs_data  = '0;
      m_head   = '0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b11, 1'b1);

      // Back-to-back load of 01,10,11,00 then wait past release
      load_seq(2'b01, 2'b10, 2'b11, 2'b00, 1'b0);
      idle(6);
      chk("done_after_burst", 32'(cfg_done), 32'd1);
      chk("bits_after_burst", 32'(bits_loaded), 32'(CL));

      // Restart from DONE with valid toggling; extra valid words after the 4th must be dropped
      load_seq(2'b10, 2'b11, 2'b01, 2'b10, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b11, 1'b0);
      idle(4);

      // Two words then silence -> timeout error, then recovery
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, 2'b01, 1'b0);
      step(1'b0, 1'b1, 2'b10, 1'b0);
      idle(8);
      chk("err_after_timeout", 32'(cfg_error), 32'd1);
      chk("bits_at_timeout", 32'(bits_loaded), 32'd2);
      load_seq(2'b11, 2'b00, 2'b01, 2'b11, 1'b0);
      idle(5);

      // Reset mid-load; later valid words ignored until start
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, 2'b01, 1'b0);
      step(1'b0, 1'b1, 2'b10, 1'b0);
      step(1'b0, 1'b1, 2'b11, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b01, 1'b0);
      load_seq(2'b00, 2'b01, 2'b10, 2'b11, 1'b0);
      idle(5);

      // start during LOAD is ignored
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, 2'b01, 1'b0);
      step(1'b1, 1'b1, 2'b10, 1'b0);
      step(1'b1, 1'b0, 2'b00, 1'b0);
      step(1'b0, 1'b1, 2'b11, 1'b0);
      step(1'b1, 1'b1, 2'b00, 1'b0);
      step(1'b1, 1'b0, 2'b00, 1'b0);
      idle(5);

      // Random traffic with varying valid density so timeouts also occur
      for (int blk = 0; blk < 12; blk++) begin
         int pct;
         pct = (blk % 4 == 0) ? 100 : (blk % 4 == 1) ? 70 : (blk % 4 == 2) ? 35 : 8;
         for (int i = 0; i < 200; i++) begin
            step(($urandom % 20) == 0, ($urandom % 100) < pct, NC'($urandom),
                 ($urandom % 250) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
